// File: rtl/sdram_access_sequencer_pkg.sv
// Shared SDRAM definitions: command codes, sequencer states,
// and timer sizing helpers.
package sdram_access_sequencer_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_PRE = 3'd2,
        CMD_RD  = 3'd3,
        CMD_WR  = 3'd4
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECIDE   = 3'd1,
        S_PRE      = 3'd2,
        S_WAIT_RP  = 3'd3,
        S_ACT      = 3'd4,
        S_WAIT_RCD = 3'd5,
        S_RW       = 3'd6
    } state_e;

    localparam int CNT_W = 8;

    // The issuing state and the exit cycle of the wait state
    // both count, so the wait counter runs from t-2 down to 0.
    function automatic logic [CNT_W-1:0] wait_load(input int t);
        return (t >= 2) ? CNT_W'(t - 2) : '0;
    endfunction

endpackage

// File: rtl/sdram_access_sequencer_if.sv
// Request, open-row tracker and SDRAM command bundle
// between a requester and the access sequencer.
interface sdram_access_sequencer_if #(
    parameter int ROW_BITS  = 13,
    parameter int BANK_BITS = 2,
    parameter int COL_BITS  = 10
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [BANK_BITS-1:0] req_bank;
    logic [ROW_BITS-1:0]  req_row;
    logic [COL_BITS-1:0]  req_col;

    logic [BANK_BITS-1:0] query_bank;
    logic [ROW_BITS-1:0]  query_row;
    logic                 row_hit;

    logic                 set_active_pulse;
    logic [BANK_BITS-1:0] set_bank;
    logic [ROW_BITS-1:0]  set_row;
    logic                 clear_active_pulse;
    logic [BANK_BITS-1:0] clear_bank;

    logic                 cmd_valid;
    logic [2:0]           cmd_code;
    logic [BANK_BITS-1:0] cmd_bank;
    logic [ROW_BITS-1:0]  cmd_addr;

    modport master (
        output req_valid, req_we, req_bank,
        output req_row, req_col, row_hit,
        input  req_ready, query_bank, query_row,
        input  set_active_pulse, set_bank, set_row,
        input  clear_active_pulse, clear_bank,
        input  cmd_valid, cmd_code, cmd_bank, cmd_addr
    );

    modport slave (
        input  req_valid, req_we, req_bank,
        input  req_row, req_col, row_hit,
        output req_ready, query_bank, query_row,
        output set_active_pulse, set_bank, set_row,
        output clear_active_pulse, clear_bank,
        output cmd_valid, cmd_code, cmd_bank, cmd_addr
    );

endinterface

// File: rtl/sdram_timer_cnt.sv
// Loadable down-counter that saturates at zero and flags it.
module sdram_timer_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sdram_access_sequencer.sv
// Single-access SDRAM sequencer: row hit goes straight to RD/WR,
// a miss always precharges then activates, honouring tRP/tRCD/tRAS.
module sdram_access_sequencer
    import sdram_access_sequencer_pkg::*;
#(
    parameter int ROW_BITS  = 13,
    parameter int BANK_BITS = 2,
    parameter int COL_BITS  = 10,
    parameter int T_RP      = 3,
    parameter int T_RCD     = 3,
    parameter int T_RAS     = 6
) (
    input logic clk,
    input logic rst_n,
    sdram_access_sequencer_if.slave bus
);

    state_e state_q;
    state_e state_d;

    logic                 we_q;
    logic [BANK_BITS-1:0] bank_q;
    logic [ROW_BITS-1:0]  row_q;
    logic [COL_BITS-1:0]  col_q;

    logic             wait_load_en;
    logic [CNT_W-1:0] wait_load_val;
    logic             wait_zero;
    logic             ras_load_en;
    logic             ras_zero;

    // One counter serves both tRP and tRCD; they never overlap.
    sdram_timer_cnt #(.W(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wait_load_en),
        .load_val (wait_load_val),
        .zero     (wait_zero)
    );

    sdram_timer_cnt #(.W(CNT_W)) u_ras_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ras_load_en),
        .load_val (CNT_W'(T_RAS)),
        .zero     (ras_zero)
    );

    assign wait_load_en  = (state_q == S_PRE) || (state_q == S_ACT);
    assign wait_load_val = (state_q == S_PRE) ? wait_load(T_RP)
                                              : wait_load(T_RCD);
    assign ras_load_en   = (state_q == S_ACT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            bank_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (state_q == S_IDLE && bus.req_valid) begin
            we_q   <= bus.req_we;
            bank_q <= bus.req_bank;
            row_q  <= bus.req_row;
            col_q  <= bus.req_col;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (bus.row_hit)   state_d = S_RW;
                else if (ras_zero) state_d = S_PRE;
            end
            S_PRE: begin
                state_d = (T_RP == 1) ? S_ACT : S_WAIT_RP;
            end
            S_WAIT_RP: begin
                if (wait_zero) state_d = S_ACT;
            end
            S_ACT: begin
                state_d = (T_RCD == 1) ? S_RW : S_WAIT_RCD;
            end
            S_WAIT_RCD: begin
                if (wait_zero) state_d = S_RW;
            end
            S_RW: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    cmd_e code;

    // Outputs are held low while reset is asserted so an abandoned
    // access cannot leak a command in the reset cycle itself.
    always_comb begin
        code                   = CMD_NOP;
        bus.req_ready          = 1'b0;
        bus.cmd_bank           = '0;
        bus.cmd_addr           = '0;
        bus.set_active_pulse   = 1'b0;
        bus.set_bank           = '0;
        bus.set_row            = '0;
        bus.clear_active_pulse = 1'b0;
        bus.clear_bank         = '0;
        if (rst_n) begin
            unique case (state_q)
                S_IDLE: begin
                    bus.req_ready = 1'b1;
                end
                S_PRE: begin
                    code                   = CMD_PRE;
                    bus.cmd_bank           = bank_q;
                    bus.clear_active_pulse = 1'b1;
                    bus.clear_bank         = bank_q;
                end
                S_ACT: begin
                    code                 = CMD_ACT;
                    bus.cmd_bank         = bank_q;
                    bus.cmd_addr         = row_q;
                    bus.set_active_pulse = 1'b1;
                    bus.set_bank         = bank_q;
                    bus.set_row          = row_q;
                end
                S_RW: begin
                    code         = we_q ? CMD_WR : CMD_RD;
                    bus.cmd_bank = bank_q;
                    bus.cmd_addr = ROW_BITS'(col_q);
                end
                default: begin
                    code = CMD_NOP;
                end
            endcase
        end
    end

    assign bus.cmd_code   = code;
    assign bus.cmd_valid  = (code != CMD_NOP);
    assign bus.query_bank = bank_q;
    assign bus.query_row  = row_q;

endmodule

// File: tb/tb_sdram_access_sequencer.sv
// Directed bench for the SDRAM access sequencer, one task per
// scenario; tb acts as requester and open-row tracker.
module tb_sdram_access_sequencer;

    localparam int RB = 13;
    localparam int BB = 2;
    localparam int CB = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sdram_access_sequencer_if #(
        .ROW_BITS(RB), .BANK_BITS(BB), .COL_BITS(CB)
    ) bus ();

    sdram_access_sequencer #(
        .ROW_BITS(RB), .BANK_BITS(BB), .COL_BITS(CB),
        .T_RP(3), .T_RCD(3), .T_RAS(6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [BB-1:0] b,
                           input logic [RB-1:0] r,
                           input logic [CB-1:0] c);
        bus.req_we    = we;
        bus.req_bank  = b;
        bus.req_row   = r;
        bus.req_col   = c;
        bus.req_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.row_hit = 1'b1;
        set_req(1'b0, 2'd3, 13'h1FFF, 10'h3FF);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.cmd_valid !== 1'b0 || bus.cmd_code !== 3'd0) begin
                errors++;
                $display("FAIL reset_cmd cyc%0d got v=%0b code=%0d exp 0",
                         i, bus.cmd_valid, bus.cmd_code);
            end
            checks++;
            if (bus.set_active_pulse !== 1'b0 ||
                bus.clear_active_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_pulses got set=%0b clr=%0b exp 0",
                         bus.set_active_pulse, bus.clear_active_pulse);
            end
        end
        checks++;
        if (bus.cmd_addr !== 13'd0 || bus.cmd_bank !== 2'd0 ||
            bus.set_row !== 13'd0 || bus.clear_bank !== 2'd0) begin
            errors++;
            $display("FAIL reset_addr got addr=%h bank=%0d exp 0",
                     bus.cmd_addr, bus.cmd_bank);
        end
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %0b exp 1", bus.req_ready);
        end
        checks++;
        if (bus.query_bank !== 2'd0 || bus.query_row !== 13'd0) begin
            errors++;
            $display("FAIL reset_query got b=%0d r=%h exp 0",
                     bus.query_bank, bus.query_row);
        end
        tick();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_hold got %0b exp 1", bus.req_ready);
        end
    endtask

    task automatic test_hit();
        bus.row_hit = 1'b1;
        set_req(1'b0, 2'd1, 13'h0A0, 10'h010);
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.cmd_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hit_c1 got v=%0b rdy=%0b exp 0 0",
                     bus.cmd_valid, bus.req_ready);
        end
        checks++;
        if (bus.query_bank !== 2'd1 || bus.query_row !== 13'h0A0) begin
            errors++;
            $display("FAIL hit_query got b=%0d r=%h exp 1 0a0",
                     bus.query_bank, bus.query_row);
        end
        tick();
        checks++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 3'd3 ||
            bus.cmd_bank !== 2'd1 || bus.cmd_addr !== 13'h010) begin
            errors++;
            $display("FAIL hit_rd got v=%0b c=%0d b=%0d a=%h exp 1 3 1 010",
                     bus.cmd_valid, bus.cmd_code, bus.cmd_bank,
                     bus.cmd_addr);
        end
        tick();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL hit_c3 got rdy=%0b v=%0b exp 1 0",
                     bus.req_ready, bus.cmd_valid);
        end
    endtask

    task automatic test_miss();
        int pre_c = -1;
        int act_c = -1;
        int wr_c  = -1;
        int ncmd  = 0;
        bus.row_hit = 1'b0;
        set_req(1'b1, 2'd2, 13'h1234, 10'h3FF);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) bus.req_valid = 1'b0;
            checks++;
            if (bus.set_active_pulse && bus.clear_active_pulse) begin
                errors++;
                $display("FAIL miss_both_pulses cyc%0d got 1 1 exp not both",
                         i);
            end
            if (bus.cmd_valid) ncmd++;
            if (bus.cmd_code == 3'd2) begin
                pre_c = i;
                checks++;
                if (bus.clear_active_pulse !== 1'b1 ||
                    bus.clear_bank !== 2'd2 || bus.cmd_bank !== 2'd2 ||
                    bus.cmd_addr !== 13'd0 || bus.cmd_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL miss_pre got clr=%0b cb=%0d a=%h exp 1 2 0",
                             bus.clear_active_pulse, bus.clear_bank,
                             bus.cmd_addr);
                end
            end
            if (bus.cmd_code == 3'd1) begin
                act_c = i;
                checks++;
                if (bus.set_active_pulse !== 1'b1 ||
                    bus.set_bank !== 2'd2 || bus.set_row !== 13'h1234 ||
                    bus.cmd_addr !== 13'h1234) begin
                    errors++;
                    $display("FAIL miss_act got set=%0b sb=%0d sr=%h exp 1 2 1234",
                             bus.set_active_pulse, bus.set_bank, bus.set_row);
                end
            end
            if (bus.cmd_code == 3'd4) begin
                wr_c = i;
                checks++;
                if (bus.cmd_addr !== 13'h3FF || bus.cmd_bank !== 2'd2) begin
                    errors++;
                    $display("FAIL miss_wr got a=%h b=%0d exp 3ff 2",
                             bus.cmd_addr, bus.cmd_bank);
                end
            end
        end
        checks++;
        if (pre_c != 2 || act_c != 5 || wr_c != 8) begin
            errors++;
            $display("FAIL miss_timing got pre=%0d act=%0d wr=%0d exp 2 5 8",
                     pre_c, act_c, wr_c);
        end
        checks++;
        if (ncmd != 3) begin
            errors++;
            $display("FAIL miss_cmd_count got %0d exp 3", ncmd);
        end
    endtask

    task automatic test_tras();
        int act1 = -1;
        int pre2 = -1;
        int wr2  = -1;
        bit accept_seen = 1'b0;
        bit b_active = 1'b0;
        bus.row_hit = 1'b0;
        set_req(1'b0, 2'd0, 13'h0005, 10'h001);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) set_req(1'b1, 2'd1, 13'h0099, 10'h002);
            if (accept_seen) begin
                bus.req_valid = 1'b0;
                accept_seen = 1'b0;
                b_active = 1'b1;
            end
            if (bus.req_ready && bus.req_valid) accept_seen = 1'b1;
            if (bus.cmd_code == 3'd1 && act1 < 0) act1 = i;
            if (bus.cmd_code == 3'd2 && act1 >= 0 && pre2 < 0) pre2 = i;
            if (bus.cmd_code == 3'd4 && b_active) begin
                wr2 = i;
                checks++;
                if (bus.cmd_bank !== 2'd1 || bus.cmd_addr !== 13'h002) begin
                    errors++;
                    $display("FAIL tras_wr got b=%0d a=%h exp 1 002",
                             bus.cmd_bank, bus.cmd_addr);
                end
            end
        end
        checks++;
        if (act1 != 5) begin
            errors++;
            $display("FAIL tras_act1 got %0d exp 5", act1);
        end
        checks++;
        if (pre2 < 0 || pre2 < act1 + 6) begin
            errors++;
            $display("FAIL tras_pre2 got %0d exp >= %0d", pre2, act1 + 6);
        end
        checks++;
        if (wr2 < 0 || wr2 != pre2 + 6) begin
            errors++;
            $display("FAIL tras_wr2 got %0d exp %0d", wr2, pre2 + 6);
        end
    endtask

    task automatic test_reset_wait_rp();
        bus.row_hit = 1'b0;
        set_req(1'b0, 2'd1, 13'h0007, 10'h003);
        tick();
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if (bus.cmd_code !== 3'd2) begin
            errors++;
            $display("FAIL rstrp_pre got %0d exp 2", bus.cmd_code);
        end
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstrp_in_reset got %0b exp 0", bus.cmd_valid);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.cmd_valid !== 1'b0 || bus.set_active_pulse !== 1'b0) begin
                errors++;
                $display("FAIL rstrp_quiet cyc%0d got v=%0b set=%0b exp 0 0",
                         i, bus.cmd_valid, bus.set_active_pulse);
            end
            checks++;
            if (bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstrp_ready cyc%0d got %0b exp 1",
                         i, bus.req_ready);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        bus.row_hit = 1'b0;
        set_req(1'b1, 2'd3, 13'h0777, 10'h055);
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) set_req(1'b0, 2'd1, 13'h0042, 10'h123);
            if (i == 10) bus.req_valid = 1'b0;
            if (i <= 8) begin
                checks++;
                if (bus.req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy cyc%0d got %0b exp 0",
                             i, bus.req_ready);
                end
            end
            if (i == 2) begin
                checks++;
                if (bus.cmd_code !== 3'd2 || bus.cmd_bank !== 2'd3) begin
                    errors++;
                    $display("FAIL b2b_pre got c=%0d b=%0d exp 2 3",
                             bus.cmd_code, bus.cmd_bank);
                end
            end
            if (i == 5) begin
                checks++;
                if (bus.cmd_code !== 3'd1 || bus.set_row !== 13'h0777) begin
                    errors++;
                    $display("FAIL b2b_act got c=%0d r=%h exp 1 0777",
                             bus.cmd_code, bus.set_row);
                end
            end
            if (i == 8) begin
                checks++;
                if (bus.cmd_code !== 3'd4 || bus.cmd_bank !== 2'd3 ||
                    bus.cmd_addr !== 13'h055) begin
                    errors++;
                    $display("FAIL b2b_wr got c=%0d b=%0d a=%h exp 4 3 055",
                             bus.cmd_code, bus.cmd_bank, bus.cmd_addr);
                end
            end
            if (i == 9) begin
                bus.row_hit = 1'b1;
                checks++;
                if (bus.req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_accept got %0b exp 1", bus.req_ready);
                end
            end
            if (i == 10) begin
                checks++;
                if (bus.query_bank !== 2'd1 || bus.query_row !== 13'h0042 ||
                    bus.req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_latch got b=%0d r=%h rdy=%0b exp 1 0042 0",
                             bus.query_bank, bus.query_row, bus.req_ready);
                end
            end
            if (i == 11) begin
                checks++;
                if (bus.cmd_code !== 3'd3 || bus.cmd_bank !== 2'd1 ||
                    bus.cmd_addr !== 13'h123) begin
                    errors++;
                    $display("FAIL b2b_rd got c=%0d b=%0d a=%h exp 3 1 123",
                             bus.cmd_code, bus.cmd_bank, bus.cmd_addr);
                end
            end
            if (i >= 12) begin
                checks++;
                if (bus.cmd_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_once cyc%0d got v=%0b rdy=%0b exp 0 1",
                             i, bus.cmd_valid, bus.req_ready);
                end
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_bank  = '0;
        bus.req_row   = '0;
        bus.req_col   = '0;
        bus.row_hit   = 1'b0;
        test_reset();
        test_hit();
        test_miss();
        test_tras();
        test_reset_wait_rp();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
